wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural register file.
- Selects writeback data (memory load vs ALU result) and commits it to the 32-entry integer register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Exports the writeback value for EX-stage forwarding and a committed-write counter for debug.

Parameters:
XLEN, 64, data width of registers and writeback paths
NREG, 32, number of architectural registers (index width log2(NREG) = 5)
CNT_W, 32, width of the committed-write counter

Ports:
clk  input  1  clock; all state updates on posedge clk
reset  input  1  synchronous active-high reset
RegWrite  input  1  from MEM/WB register: write enable for this instruction
MemtoReg  input  1  from MEM/WB register: 1 selects ReadData, 0 selects ALU_result
ReadData  input  XLEN  from MEM/WB register: load data
ALU_result  input  XLEN  from MEM/WB register: ALU result
rd  input  5  from MEM/WB register: destination register index
rs1  input  5  ID-stage source register 1 index
rs2  input  5  ID-stage source register 2 index
ReadData1  output  XLEN  value of rs1 (combinational, bypassed)
ReadData2  output  XLEN  value of rs2 (combinational, bypassed)
wb_data  output  XLEN  selected writeback value (combinational), for forwarding to EX
wb_en  output  1  effective write enable = RegWrite & (rd != 0), for the forwarding unit
dbg_addr  input  5  debug read index
dbg_data  output  XLEN  raw stored value of register dbg_addr (no bypass)
write_count  output  CNT_W  number of committed register writes since reset

Behaviour:
- Writeback mux:
  - wb_data = MemtoReg ? ReadData : ALU_result; purely combinational.
  - wb_data is valid regardless of RegWrite.
- Effective write:
  - wb_en = RegWrite & (rd != 0).
  - Writes to x0 are discarded.
  - Storage for x0 is never written; it reads 0 at all times.
- Commit:
  - On posedge clk with reset=0 and wb_en=1: regs[rd] <= wb_data and write_count <= write_count + 1.
  - Commit has one-cycle latency: visible in dbg_data the cycle after the edge.
- Counter:
  - write_count wraps modulo 2^CNT_W (all-ones + 1 -> 0).
  - It does not count discarded writes (RegWrite=1 with rd=0, or RegWrite=0).
- Read ports, combinational:
  - ReadDataN = 0 if rsN == 0.
  - Otherwise wb_data if wb_en && rsN == rd (write-before-read bypass in the same cycle).
  - Otherwise regs[rsN].
  - The bypass applies independently to both ports; rs1 == rs2 == rd returns wb_data on both.
- dbg_data:
  - Returns regs[dbg_addr] without bypass (0 for index 0).
  - Reflects only committed state.
- Reset:
  - On posedge clk with reset=1, all regs <= 0 and write_count <= 0.
  - A simultaneous write is suppressed; reset wins.
  - While reset is held, ReadData1/2 still bypass wb_data when wb_en matches. The bypass is combinational and the upstream MEM/WB register is expected to present RegWrite=0 during reset.
  - Reset asserted mid-stream discards the in-flight writeback for that edge.
  - After reset deasserts, the first edge with wb_en commits normally.
- Timing relationship:
  - The MEM/WB register updates on negedge clk; this block samples on posedge.
  - Inputs are therefore stable for half a cycle before commit.
  - No input registering occurs inside this block.
- Back-to-back writes to the same rd on consecutive edges: the last write wins. Each write increments write_count.
- X handling: rd/rs indices are always in range (NREG = 32 with 5-bit indices), so no out-of-range case exists.

Test Plan:
- Reset clears state: write nonzero values to x1..x31, assert reset for 1 edge -> dbg_data = 0 for all 32 indices, write_count = 0.
- ALU writeback commit: RegWrite=1, MemtoReg=0, ALU_result=64'h0000_0000_DEAD_BEEF, rd=5; one posedge -> dbg_addr=5 gives 64'hDEADBEEF, write_count = 1.
- Load writeback plus bypass:
  - Stimulus: MemtoReg=1, ReadData=64'h1234_5678_9ABC_DEF0, ALU_result=64'hFFFF, rd=7, rs1=7, rs2=7, before the edge.
  - Required: ReadData1 = ReadData2 = 64'h123456789ABCDEF0 combinationally; wb_en=1; after the edge, dbg_data(7) holds the same value.
- x0 protection: RegWrite=1, rd=0, ALU_result=64'hFF; rs1=0 -> ReadData1 = 0, wb_en = 0, dbg_data(0) = 0, write_count unchanged.
- Reset vs write collision: reset=1 and RegWrite=1, rd=3, ALU_result=64'h55 on the same edge -> dbg_data(3) = 0, write_count = 0; the next edge with reset=0 and the same inputs gives dbg_data(3) = 64'h55, write_count = 1.
- Counter wrap and discarded writes:
  - Stimulus: force write_count to 32'hFFFF_FFFF via 2^32-1 writes, or a bench hierarchical deposit.
  - Required: one write with rd=9 -> write_count = 0; a following cycle with RegWrite=0 -> write_count stays 0, regs[9] unchanged.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus the 32-entry architectural integer register file.
//
// Picks the writeback value (load data or ALU result), commits it to the register
// file on the rising clock edge, and serves the two ID-stage read ports with a
// same-cycle write-to-read bypass. It also exposes the writeback value and its
// effective enable to the EX forwarding unit, a raw debug read port and a
// committed-write counter.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   RegWrite, MemtoReg      MEM/WB control: write enable, load-data select
//   ReadData, ALU_result    MEM/WB data: load data, ALU result
//   rd                      MEM/WB destination register index
//   rs1, rs2                ID-stage source indices
//   ReadData1, ReadData2    bypassed register values (combinational)
//   wb_data, wb_en          selected writeback value and effective write enable
//   dbg_addr, dbg_data      raw committed register contents (no bypass)
//   write_count             committed writes since reset, wraps modulo 2^CNT_W
//
// The MEM/WB register upstream changes on the falling edge, so every input is
// stable for half a cycle before the commit edge; nothing is registered on entry.
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic                     MemtoReg,
  input  logic [XLEN-1:0]          ReadData,
  input  logic [XLEN-1:0]          ALU_result,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  output logic [XLEN-1:0]          ReadData1,
  output logic [XLEN-1:0]          ReadData2,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic [CNT_W-1:0]         write_count
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] write_count_q;
  logic [CNT_W-1:0] write_count_d;

  // Writeback select is valid whether or not the instruction writes.
  assign wb_data = MemtoReg ? ReadData : ALU_result;

  // x0 is hardwired to zero, so a write aimed at it is not a write at all.
  assign wb_en = RegWrite && (rd != '0);

  // Next state. Entry 0 is only ever loaded with its reset value, so it is a
  // constant zero after synthesis; the read paths force zero for index 0 anyway.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    write_count_d = write_count_q;
    if (wb_en) begin
      regs_d[rd]    = wb_data;
      write_count_d = write_count_q + CNT_W'(1);
    end
  end

  // Reset takes priority over a writeback arriving on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      write_count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      write_count_q <= write_count_d;
    end
  end

  // Read ports: zero register first, then the in-flight writeback (it commits
  // on the coming edge, so ID must already see it), then stored state.
  always_comb begin
    if (rs1 == '0) begin
      ReadData1 = '0;
    end else if (wb_en && (rs1 == rd)) begin
      ReadData1 = wb_data;
    end else begin
      ReadData1 = regs_q[rs1];
    end
  end

  always_comb begin
    if (rs2 == '0) begin
      ReadData2 = '0;
    end else if (wb_en && (rs2 == rd)) begin
      ReadData2 = wb_data;
    end else begin
      ReadData2 = regs_q[rs2];
    end
  end

  // Debug port shows committed state only, never the bypass.
  assign dbg_data    = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign write_count = write_count_q;

endmodule
